prog_dispatcher: RTL and testbench

Sequencer that sits directly upstream of the lab3 processor core and drives its `start_i`/`start_addr` pair. It holds a small table of program start addresses. On command it launches each program in turn with a one-cycle start pulse and waits for the core's `done`. It measures each run's cycle count and aborts on a hung program, replacing hand-sequenced start/wait stimulus with a synthesizable launcher.

---
 rtl/prog_dispatcher.sv | 165 ++++++++++++++++
 tb/tb_prog_dispatcher.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_dispatcher.sv
// Program launcher for the lab3 core: steps through a table of start addresses,
// pulses start for each entry, times each run and aborts on a hung program.
module prog_dispatcher #(
    parameter int ADDR_W    = 8,
    parameter int NUM_PROGS = 4,
    parameter int IDX_W     = 2,
    parameter int CNT_W     = 16,
    parameter logic [CNT_W-1:0] MAX_CYC = 16'd50000
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              load_en_i,
    input  logic [IDX_W-1:0]  load_idx_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              go_i,
    input  logic [IDX_W-1:0]  last_i,
    input  logic              cpu_done_i,
    output logic              cpu_start_o,
    output logic [ADDR_W-1:0] cpu_start_addr_o,
    output logic              busy_o,
    output logic [IDX_W-1:0]  prog_idx_o,
    output logic [CNT_W-1:0]  cycles_o,
    output logic              cycles_valid_o,
    output logic              timeout_o,
    output logic              all_done_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        BLANK  = 3'd2,
        RUN    = 3'd3,
        REPORT = 3'd4,
        FIN    = 3'd5
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] table_r [NUM_PROGS];
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  last_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              cpu_start_r;
    logic [ADDR_W-1:0] start_addr_r;
    logic              busy_r;
    logic [IDX_W-1:0]  prog_idx_r;
    logic [CNT_W-1:0]  cycles_r;
    logic              cycles_valid_r;
    logic              timeout_r;
    logic              all_done_r;

    logic [ADDR_W-1:0] first_addr_s;
    logic [IDX_W-1:0]  next_idx_s;
    logic [CNT_W-1:0]  cnt_plus_s;

    // A table write to entry 0 in the same cycle as go must be launched with the new value
    always_comb begin
        first_addr_s = table_r[0];
        if (load_en_i && (load_idx_i == {IDX_W{1'b0}})) begin
            first_addr_s = load_addr_i;
        end else begin
            first_addr_s = table_r[0];
        end
    end

    assign next_idx_s = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
    assign cnt_plus_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

    // Sequencer FSM with all outputs registered on the transition into each state
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_r        <= IDLE;
            for (int i = 0; i < NUM_PROGS; i++) begin
                table_r[i] <= {ADDR_W{1'b0}};
            end
            idx_r          <= {IDX_W{1'b0}};
            last_r         <= {IDX_W{1'b0}};
            cnt_r          <= {CNT_W{1'b0}};
            cpu_start_r    <= 1'b0;
            start_addr_r   <= {ADDR_W{1'b0}};
            busy_r         <= 1'b0;
            prog_idx_r     <= {IDX_W{1'b0}};
            cycles_r       <= {CNT_W{1'b0}};
            cycles_valid_r <= 1'b0;
            timeout_r      <= 1'b0;
            all_done_r     <= 1'b0;
        end else begin
            cpu_start_r    <= 1'b0;
            cycles_valid_r <= 1'b0;
            all_done_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (load_en_i) begin
                        table_r[load_idx_i] <= load_addr_i;
                    end
                    if (go_i) begin
                        idx_r        <= {IDX_W{1'b0}};
                        last_r       <= last_i;
                        timeout_r    <= 1'b0;
                        cpu_start_r  <= 1'b1;
                        start_addr_r <= first_addr_s;
                        prog_idx_r   <= {IDX_W{1'b0}};
                        busy_r       <= 1'b1;
                        state_r      <= LAUNCH;
                    end else begin
                        busy_r       <= 1'b0;
                    end
                end
                LAUNCH: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= BLANK;
                end
                // done is deliberately ignored here so a stale done from the previous run is dropped
                BLANK: begin
                    state_r <= RUN;
                end
                RUN: begin
                    cnt_r <= cnt_plus_s;
                    if (cpu_done_i) begin
                        cycles_r       <= cnt_plus_s;
                        cycles_valid_r <= 1'b1;
                        state_r        <= REPORT;
                    end else if (cnt_plus_s == MAX_CYC) begin
                        cycles_r       <= MAX_CYC;
                        timeout_r      <= 1'b1;
                        cycles_valid_r <= 1'b1;
                        state_r        <= REPORT;
                    end else begin
                        state_r        <= RUN;
                    end
                end
                REPORT: begin
                    if (timeout_r || (idx_r == last_r)) begin
                        all_done_r   <= 1'b1;
                        state_r      <= FIN;
                    end else begin
                        idx_r        <= next_idx_s;
                        prog_idx_r   <= next_idx_s;
                        cpu_start_r  <= 1'b1;
                        start_addr_r <= table_r[next_idx_s];
                        state_r      <= LAUNCH;
                    end
                end
                FIN: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign cpu_start_o      = cpu_start_r;
    assign cpu_start_addr_o = start_addr_r;
    assign busy_o           = busy_r;
    assign prog_idx_o       = prog_idx_r;
    assign cycles_o         = cycles_r;
    assign cycles_valid_o   = cycles_valid_r;
    assign timeout_o        = timeout_r;
    assign all_done_o       = all_done_r;

endmodule

// File: tb/tb_prog_dispatcher.sv
// Scoreboard bench for prog_dispatcher: a behavioural core answers each start
// pulse with done after a chosen latency; launches and reports are checked.
module tb_prog_dispatcher;

    localparam int ADDR_W = 8;
    localparam int IDX_W  = 2;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              reset_i;
    logic              load_en_i;
    logic [IDX_W-1:0]  load_idx_i;
    logic [ADDR_W-1:0] load_addr_i;
    logic              go_i;
    logic [IDX_W-1:0]  last_i;
    logic              cpu_done_i;
    logic              cpu_start_o;
    logic [ADDR_W-1:0] cpu_start_addr_o;
    logic              busy_o;
    logic [IDX_W-1:0]  prog_idx_o;
    logic [CNT_W-1:0]  cycles_o;
    logic              cycles_valid_o;
    logic              timeout_o;
    logic              all_done_o;

    prog_dispatcher #(
        .ADDR_W(ADDR_W), .NUM_PROGS(4), .IDX_W(IDX_W), .CNT_W(CNT_W), .MAX_CYC(16'd20)
    ) dut (
        .clock_i(clk), .reset_i(reset_i), .load_en_i(load_en_i), .load_idx_i(load_idx_i),
        .load_addr_i(load_addr_i), .go_i(go_i), .last_i(last_i), .cpu_done_i(cpu_done_i),
        .cpu_start_o(cpu_start_o), .cpu_start_addr_o(cpu_start_addr_o), .busy_o(busy_o),
        .prog_idx_o(prog_idx_o), .cycles_o(cycles_o), .cycles_valid_o(cycles_valid_o),
        .timeout_o(timeout_o), .all_done_o(all_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int alldone_cnt = 0;
    int exp_alldone = 0;

    // scoreboard queues
    int exp_addr_q[$];
    int exp_sidx_q[$];
    int exp_cyc_q[$];
    int exp_ridx_q[$];
    int exp_to_q[$];
    int lat_q[$];
    int stale_q[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int idx, input int addr);
        load_en_i = 1'b1; load_idx_i = IDX_W'(idx); load_addr_i = ADDR_W'(addr);
        tick(1);
        load_en_i = 1'b0;
    endtask

    task automatic go(input int last);
        go_i = 1'b1; last_i = IDX_W'(last);
        tick(1);
        go_i = 1'b0;
    endtask

    // expected launch plus the core's response latency (0 = never done)
    task automatic exp_launch(input int addr, input int idx, input int lat, input int stale);
        exp_addr_q.push_back(addr); exp_sidx_q.push_back(idx);
        lat_q.push_back(lat); stale_q.push_back(stale);
    endtask

    task automatic exp_report(input int cyc, input int idx, input int to);
        exp_cyc_q.push_back(cyc); exp_ridx_q.push_back(idx); exp_to_q.push_back(to);
    endtask

    task automatic wait_fin(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            if (all_done_o) seen = 1'b1;
            else tick(1);
        end
        if (!seen) check_eq({tag, "_fin_timeout"}, 32'd0, 32'd1);
        tick(1);
        exp_alldone++;
        check_eq({tag, "_idle_busy"}, busy_o, 32'd0);
        check_eq({tag, "_alldone_cnt"}, alldone_cnt, exp_alldone);
        check_eq({tag, "_start_q_left"}, exp_addr_q.size(), 32'd0);
        check_eq({tag, "_report_q_left"}, exp_cyc_q.size(), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_start"}, cpu_start_o, 32'd0);
        check_eq({tag, "_addr"}, cpu_start_addr_o, 32'd0);
        check_eq({tag, "_busy"}, busy_o, 32'd0);
        check_eq({tag, "_idx"}, prog_idx_o, 32'd0);
        check_eq({tag, "_cycles"}, cycles_o, 32'd0);
        check_eq({tag, "_valid"}, cycles_valid_o, 32'd0);
        check_eq({tag, "_timeout"}, timeout_o, 32'd0);
        check_eq({tag, "_alldone"}, all_done_o, 32'd0);
    endtask

    // output monitor: pops expectations on every start pulse and report pulse
    always @(negedge clk) begin
        if (cpu_start_o) begin
            if (exp_addr_q.size() == 0) begin
                check_eq("extra_start", 32'd1, 32'd0);
            end else begin
                check_eq("start_addr", cpu_start_addr_o, exp_addr_q.pop_front());
                check_eq("start_idx", prog_idx_o, exp_sidx_q.pop_front());
            end
        end
        if (cycles_valid_o) begin
            if (exp_cyc_q.size() == 0) begin
                check_eq("extra_report", 32'd1, 32'd0);
            end else begin
                check_eq("report_cycles", cycles_o, exp_cyc_q.pop_front());
                check_eq("report_idx", prog_idx_o, exp_ridx_q.pop_front());
                check_eq("report_timeout", timeout_o, exp_to_q.pop_front());
            end
        end
        if (all_done_o) alldone_cnt++;
    end

    // behavioural core: done first sampled high k RUN edges after launch
    always begin
        @(negedge clk);
        if (cpu_start_o && !reset_i && lat_q.size() > 0) begin
            int lat;
            int stale;
            lat   = lat_q.pop_front();
            stale = stale_q.pop_front();
            if (lat > 0) begin
                if (stale != 0) cpu_done_i = 1'b1;
                for (int i = 1; i <= lat + 1; i++) begin
                    @(negedge clk);
                    if (i == 2) cpu_done_i = 1'b0;
                    if (i == lat + 1) cpu_done_i = 1'b1;
                end
                @(negedge clk);
                cpu_done_i = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1; load_en_i = 1'b0; load_idx_i = '0; load_addr_i = '0;
        go_i = 1'b0; last_i = '0; cpu_done_i = 1'b0;
        tick(3);
        check_zero("reset");
        reset_i = 1'b0;
        tick(1);

        // single program
        load(0, 0);
        exp_launch(0, 0, 10, 0); exp_report(10, 0, 0);
        go(0);
        wait_fin("single");

        // three programs in order
        load(0, 0); load(1, 93); load(2, 138);
        exp_launch(0, 0, 5, 0);   exp_report(5, 0, 0);
        exp_launch(93, 1, 7, 0);  exp_report(7, 1, 0);
        exp_launch(138, 2, 3, 0); exp_report(3, 2, 0);
        go(2);
        wait_fin("three");

        // stale done held through LAUNCH and BLANK
        exp_launch(0, 0, 4, 1); exp_report(4, 0, 0);
        go(0);
        wait_fin("stale");

        // timeout aborts the sequence before entry 1
        load(0, 10); load(1, 20);
        exp_launch(10, 0, 0, 0); exp_report(20, 0, 1);
        go(1);
        wait_fin("timeout");
        check_eq("timeout_sticky", timeout_o, 32'd1);
        check_eq("timeout_cycles_hold", cycles_o, 32'd20);
        exp_launch(10, 0, 3, 0); exp_report(3, 0, 0);
        go(0);
        check_eq("timeout_cleared", timeout_o, 32'd0);
        wait_fin("after_timeout");

        // go and table write while busy are ignored
        exp_launch(10, 0, 8, 0); exp_report(8, 0, 0);
        go(0);
        tick(3);
        go_i = 1'b1; last_i = 2'd3; load_en_i = 1'b1; load_idx_i = 2'd0; load_addr_i = 8'hFF;
        tick(1);
        go_i = 1'b0; load_en_i = 1'b0;
        wait_fin("ignored");
        exp_launch(10, 0, 2, 0); exp_report(2, 0, 0);
        go(0);
        wait_fin("entry0_kept");

        // reset mid-RUN clears everything, no all_done pulse
        exp_launch(10, 0, 0, 0);
        go(0);
        tick(6);
        reset_i = 1'b1;
        tick(2);
        check_zero("midrun_reset");
        check_eq("midrun_no_alldone", alldone_cnt, exp_alldone);
        reset_i = 1'b0; go_i = 1'b1; last_i = 2'd0;
        exp_launch(0, 0, 2, 0); exp_report(2, 0, 0);
        tick(1);
        go_i = 1'b0;
        wait_fin("post_reset");

        // write and go in the same cycle: new value launched
        exp_launch(55, 0, 6, 0); exp_report(6, 0, 0);
        load_en_i = 1'b1; load_idx_i = 2'd0; load_addr_i = 8'd55;
        go_i = 1'b1; last_i = 2'd0;
        tick(1);
        load_en_i = 1'b0; go_i = 1'b0;
        wait_fin("write_and_go");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
